// File: rtl/b_tile_feeder.sv
// Stores a DIM x DIM signed B tile row by row, then streams it into the memB skew buffer followed by 2*DIM-1 zero rows.
// Outputs are registered; the first row appears the cycle after start is sampled; en_out stays high for 3*DIM-1 cycles.
module b_tile_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int ROW_W   = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [ROW_W-1:0]          wr_row,
  input  logic signed [BITS_AB-1:0] wr_data [DIM-1:0],
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic [DIM-1:0]            loaded,
  output logic                      en_out,
  output logic signed [BITS_AB-1:0] Bout [DIM-1:0]
);

  localparam int FL_W = (2 * DIM - 1 > 1) ? $clog2(2 * DIM - 1) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);
  localparam logic [FL_W-1:0]  LAST_FL  = FL_W'(2 * DIM - 2);
  localparam logic [ROW_W:0]   DIM_L    = (ROW_W + 1)'(DIM);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

  state_t                    r_state;
  logic [ROW_W-1:0]          r_row;
  logic [FL_W-1:0]           r_fl;
  logic signed [BITS_AB-1:0] r_tile [DIM-1:0][DIM-1:0];
  logic [DIM-1:0]            r_loaded;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_en;
  logic signed [BITS_AB-1:0] r_bout [DIM-1:0];

  logic                      w_row_ok;
  logic [ROW_W-1:0]          w_next_row;

  // Rows beyond DIM only exist when DIM is not a power of two.
  assign w_row_ok   = ({1'b0, wr_row} < DIM_L);
  assign w_next_row = r_row + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_fl     <= '0;
      r_loaded <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_en     <= 1'b0;
      for (int r = 0; r < DIM; r++) begin
        r_bout[r] <= '0;
        for (int c = 0; c < DIM; c++) r_tile[r][c] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_en) begin
            if (w_row_ok) begin
              r_tile[wr_row]   <= wr_data;
              r_loaded[wr_row] <= 1'b1;
            end
          end else if (start && !abort) begin
            r_state <= S_FEED;
            r_row   <= '0;
            r_bout  <= r_tile[0];
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FEED, S_FLUSH: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            for (int i = 0; i < DIM; i++) r_bout[i] <= '0;
          end else if (r_state == S_FEED) begin
            if (r_row == LAST_ROW) begin
              r_state <= S_FLUSH;
              r_fl    <= '0;
              for (int i = 0; i < DIM; i++) r_bout[i] <= '0;
            end else begin
              r_row  <= w_next_row;
              r_bout <= r_tile[w_next_row];
            end
          end else if (r_fl == LAST_FL) begin
            // Last zero row is on the bus; the next cycle is the done pulse.
            r_state  <= S_DONE;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_loaded <= '0;
          end else begin
            r_fl <= r_fl + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign loaded = r_loaded;
  assign en_out = r_en;
  assign Bout   = r_bout;

endmodule

// File: tb/tb_b_tile_feeder.sv
// Bench for b_tile_feeder (DIM=4): directed scenarios plus random traffic, compared each cycle against a stream-position model.
module tb_b_tile_feeder;
  localparam int DIM  = 4;
  localparam int BITS = 8;
  localparam int RW   = 2;
  localparam int SLEN = 3 * DIM - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   wr_en = 1'b0;
  logic [RW-1:0]          wr_row = '0;
  logic signed [BITS-1:0] wr_data [DIM-1:0];
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic                   busy, done, en_out;
  logic [DIM-1:0]         loaded;
  logic signed [BITS-1:0] Bout [DIM-1:0];

  b_tile_feeder #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .start(start), .abort(abort), .busy(busy), .done(done), .loaded(loaded),
    .en_out(en_out), .Bout(Bout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit running = 1'b0;

  // Model: stored tile, loaded flags, and position within the output stream
  // (-1 idle, 0..SLEN-1 en_out high, SLEN the done cycle).
  logic [BITS-1:0] m_tile [DIM][DIM];
  logic [DIM-1:0]  m_loaded;
  int              m_pos;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos    <= -1;
      m_loaded <= '0;
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) m_tile[r][c] <= '0;
    end else if (m_pos == -1) begin
      if (wr_en) begin
        for (int c = 0; c < DIM; c++) m_tile[wr_row][c] <= wr_data[c];
        m_loaded[wr_row] <= 1'b1;
      end else if (start && !abort) begin
        m_pos <= 0;
      end
    end else if (m_pos < SLEN) begin
      if (abort) m_pos <= -1;
      else begin
        m_pos <= m_pos + 1;
        if (m_pos + 1 == SLEN) m_loaded <= '0;
      end
    end else begin
      m_pos <= -1;
    end
  end

  function automatic logic [31:0] pack_bout();
    logic [31:0] v = '0;
    for (int i = 0; i < DIM; i++) v[i*8 +: 8] = Bout[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_bout();
    logic [31:0] v = '0;
    if (m_pos >= 0 && m_pos < DIM)
      for (int i = 0; i < DIM; i++) v[i*8 +: 8] = m_tile[m_pos][i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      logic exp_en;
      exp_en = (m_pos >= 0 && m_pos < SLEN);
      chk("en_out", 32'(en_out), 32'(exp_en));
      chk("busy", 32'(busy), 32'(exp_en));
      chk("done", 32'(done), 32'(m_pos == SLEN));
      chk("bout", pack_bout(), exp_bout());
      chk("loaded", 32'(loaded), 32'(m_loaded));
    end
  end

  // All tasks start and end at a falling edge.
  task automatic write_row(input int r, input logic [31:0] d);
    wr_en  = 1'b1;
    wr_row = RW'(r);
    for (int i = 0; i < DIM; i++) wr_data[i] = d[i*8 +: 8];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int en_cnt;
    int done_at;
    bit seen;
    logic [31:0] d;
    for (int i = 0; i < DIM; i++) wr_data[i] = '0;
    #1 rst_n = 1'b0;
    running = 1'b1;
    idle(2);
    chk("reset_en", 32'(en_out), 32'd0);
    chk("reset_bout", pack_bout(), 32'd0);
    chk("reset_loaded", 32'(loaded), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Basic stream: element[r][i] = 16*r + i.
    for (int r = 0; r < DIM; r++) begin
      for (int i = 0; i < DIM; i++) d[i*8 +: 8] = 8'(16 * r + i);
      write_row(r, d);
    end
    chk("loaded_full", 32'(loaded), 32'hF);
    start_pulse();
    en_cnt = 0;
    done_at = 0;
    for (int k = 1; k <= 14; k++) begin
      if (en_out) en_cnt++;
      if (done) done_at = k;
      if (k == 1) chk("row0_lit", pack_bout(), 32'h03020100);
      if (k == 3) chk("row2_lit", pack_bout(), 32'h23222120);
      if (k == 5) chk("flush_zero_lit", pack_bout(), 32'h0);
      @(negedge clk);
    end
    chk("en_cycles", 32'(en_cnt), 32'd11);
    chk("done_cycle", 32'(done_at), 32'd12);
    chk("loaded_cleared", 32'(loaded), 32'd0);

    // Negative values pass bit-exact.
    write_row(1, 32'h80FF7F00);
    start_pulse();
    @(negedge clk);
    chk("neg_row_lit", pack_bout(), 32'h80FF7F00);
    idle(13);

    // start together with a write: write wins.
    wr_en = 1'b1; wr_row = 2'd3; start = 1'b1;
    for (int i = 0; i < DIM; i++) wr_data[i] = 8'(8'h4D + 8'h0F * i);
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    chk("collide_busy", 32'(busy), 32'd0);
    chk("collide_loaded", 32'(loaded), 32'h8);
    idle(1);

    // Write during FEED and start during FLUSH are both ignored.
    start_pulse();
    en_cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      if (en_out) en_cnt++;
      wr_en = (k == 2);
      start = (k == 6);
      wr_row = 2'd0;
      for (int i = 0; i < DIM; i++) wr_data[i] = 8'hEE;
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0;
    chk("flush_start_en_cycles", 32'(en_cnt), 32'd11);
    start_pulse();
    chk("row0_kept_lit", pack_bout(), 32'h03020100);
    idle(3);
    chk("row3_new_lit", pack_bout(), 32'h7A6B5C4D);
    idle(11);

    // Abort while row 2 is presented.
    start_pulse();
    idle(2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_en", 32'(en_out), 32'd0);
    chk("abort_bout", pack_bout(), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    start_pulse();
    chk("restart_row0_lit", pack_bout(), 32'h03020100);
    idle(11);
    chk("prev_done_lit", 32'(done), 32'd1);

    // Back-to-back: start right after the done cycle.
    @(negedge clk);
    start_pulse();
    chk("b2b_row0_lit", pack_bout(), 32'h03020100);
    chk("b2b_loaded_lit", 32'(loaded), 32'd0);
    idle(14);

    // Async reset mid-FEED.
    start_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(en_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_bout", pack_bout(), 32'd0);
    chk("arst_loaded", 32'(loaded), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    start_pulse();
    idle(1);
    chk("arst_tile_zero_lit", pack_bout(), 32'd0);
    idle(14);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_row = RW'($urandom_range(0, DIM - 1));
      for (int i = 0; i < DIM; i++) wr_data[i] = 8'($urandom);
      start  = ($urandom_range(0, 5) == 0);
      abort  = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    idle(2);
    running = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
